// File: rtl/masked_sbox_out_reg.sv
// masked_sbox_out_reg
//   Register stage after the 5-share masked S-box layer of the threshold
//   implementation PRINCE datapath. It forms a glitch-stopping register boundary
//   for all five output shares. It also decouples the S-box layer from the
//   following linear layer through a 2-entry valid/ready skid buffer.
//
//   state | meaning
//   ------+----------------------------------------------
//   EMPTY | nothing held, out_valid = 0
//   ONE   | main register M valid and driving out_*
//   TWO   | M valid, skid register S holds the next set
//
// Parameters
//   WIDTH     bits per share (4 x number of S-boxes)
//
// Ports
//   clk, rst              clock (rising edge) and synchronous active-high reset
//   in_valid / in_ready   upstream handshake; in_ready comes from the state register
//   in_v..in_z            the five S-box output shares
//   out_valid / out_ready downstream handshake
//   out_v..out_z          registered shares held in M
//   occupancy             number of entries held (0..2)
//   rnd                   only present with PRINCE_SBOX_REMASK_EN: 4*WIDTH bits of
//                         fresh randomness, applied as a remask on every capture
//
// Optional feature macro: PRINCE_SBOX_REMASK_EN
module masked_sbox_out_reg #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_v,
  input  logic [WIDTH-1:0]   in_w,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [WIDTH-1:0]   in_z,
`ifdef PRINCE_SBOX_REMASK_EN
  input  logic [4*WIDTH-1:0] rnd,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_v,
  output logic [WIDTH-1:0]   out_w,
  output logic [WIDTH-1:0]   out_x,
  output logic [WIDTH-1:0]   out_y,
  output logic [WIDTH-1:0]   out_z,
  output logic [1:0]         occupancy
);

  localparam int NSH = 5;

  // The encoding equals the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] in_sh  [NSH];
  logic [WIDTH-1:0] cap_sh [NSH];
  logic [WIDTH-1:0] m_q    [NSH];
  logic [WIDTH-1:0] m_d    [NSH];
  logic [WIDTH-1:0] s_q    [NSH];
  logic [WIDTH-1:0] s_d    [NSH];
  logic             push, pop;

  assign in_sh[0] = in_v;
  assign in_sh[1] = in_w;
  assign in_sh[2] = in_x;
  assign in_sh[3] = in_y;
  assign in_sh[4] = in_z;

  // Value written into M or S on a push. The remask XORs only randomness into
  // each share. Share z receives all four masks, so the XOR of the five shares
  // is unchanged. Shares are never combined with one another here.
`ifdef PRINCE_SBOX_REMASK_EN
  logic [WIDTH-1:0] r0, r1, r2, r3;
  assign r0 = rnd[WIDTH-1:0];
  assign r1 = rnd[2*WIDTH-1:WIDTH];
  assign r2 = rnd[3*WIDTH-1:2*WIDTH];
  assign r3 = rnd[4*WIDTH-1:3*WIDTH];

  always_comb begin
    cap_sh[0] = in_sh[0] ^ r0;
    cap_sh[1] = in_sh[1] ^ r1;
    cap_sh[2] = in_sh[2] ^ r2;
    cap_sh[3] = in_sh[3] ^ r3;
    cap_sh[4] = in_sh[4] ^ r0 ^ r1 ^ r2 ^ r3;
  end
`else
  always_comb begin
    for (int i = 0; i < NSH; i++) begin
      cap_sh[i] = in_sh[i];
    end
  end
`endif

  // in_ready depends only on the state register; rst masks it so nothing is
  // offered as accepted while reset is asserted.
  assign in_ready  = (state_q != TWO) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NSH; i++) begin
      m_d[i] = m_q[i];
      s_d[i] = s_q[i];
    end
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          for (int i = 0; i < NSH; i++) m_d[i] = cap_sh[i];
        end
      end
      ONE: begin
        if (push && pop) begin
          for (int i = 0; i < NSH; i++) m_d[i] = cap_sh[i];
        end else if (push) begin
          state_d = TWO;
          for (int i = 0; i < NSH; i++) s_d[i] = cap_sh[i];
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // The S to M move applies no new mask.
        if (pop) begin
          state_d = ONE;
          for (int i = 0; i < NSH; i++) m_d[i] = s_q[i];
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      for (int i = 0; i < NSH; i++) begin
        m_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NSH; i++) begin
        m_q[i] <= m_d[i];
        s_q[i] <= s_d[i];
      end
    end
  end

  assign out_v = m_q[0];
  assign out_w = m_q[1];
  assign out_x = m_q[2];
  assign out_y = m_q[3];
  assign out_z = m_q[4];

endmodule

// File: tb/tb_masked_sbox_out_reg.sv
module tb_masked_sbox_out_reg;
  localparam int W = 64;
  typedef logic [5*W-1:0] set_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_v, in_w, in_x, in_y, in_z;
  logic [4*W-1:0] rnd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_v, out_w, out_x, out_y, out_z;
  logic [1:0]   occupancy;

  int   total = 0;
  int   bad = 0;
  int   mocc = 0;
  bit   last_push;
  set_t sb[$];
  logic [W-1:0] raw_q[$];

  masked_sbox_out_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_v(in_v), .in_w(in_w), .in_x(in_x), .in_y(in_y), .in_z(in_z),
`ifdef PRINCE_SBOX_REMASK_EN
    .rnd(rnd),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_v(out_v), .out_w(out_w), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic set_t exp_capture();
    logic [W-1:0] r0, r1, r2, r3;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0;
`ifdef PRINCE_SBOX_REMASK_EN
    r0 = rnd[W-1:0];
    r1 = rnd[2*W-1:W];
    r2 = rnd[3*W-1:2*W];
    r3 = rnd[4*W-1:3*W];
`endif
    return {in_v ^ r0, in_w ^ r1, in_x ^ r2, in_y ^ r3, in_z ^ r0 ^ r1 ^ r2 ^ r3};
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [W-1:0] e, input bit ordy);
    in_valid = v; in_v = a; in_w = b; in_x = c; in_y = d; in_z = e;
    out_ready = ordy;
  endtask

  // Advances one clock edge and updates the bench's own model of the buffer.
  task automatic clk_step();
    bit push, pop;
    push = in_valid && (mocc != 2);
    pop  = out_ready && (mocc != 0);
    if (pop) begin
      void'(sb.pop_front());
      void'(raw_q.pop_front());
    end
    if (push) begin
      sb.push_back(exp_capture());
      raw_q.push_back(in_v ^ in_w ^ in_x ^ in_y ^ in_z);
    end
    last_push = push;
    mocc = mocc + int'(push) - int'(pop);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
    rnd = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    total++; if ({out_v, out_w, out_x, out_y, out_z} !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", {out_v, out_w, out_x, out_y, out_z}); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); end
    mocc = 0; sb.delete(); raw_q.delete();
    @(negedge clk);
  endtask

  task automatic test_single_push();
    drive(1'b1, 64'h0123456789ABCDEF, '0, '0, '0, '0, 1'b1);
    clk_step();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%0b exp=1", out_valid); end
    total++; if (out_v !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL single_out_v got=%h exp=0123456789abcdef", out_v); end
    total++; if ({out_w, out_x, out_y, out_z} !== '0) begin bad++; $display("FAIL single_out_wxyz got=%h exp=0", {out_w, out_x, out_y, out_z}); end
    total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL single_occupancy got=%0d exp=1", occupancy); end
    clk_step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), W'(i) << 8, '0, '0, '0, 1'b1);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready i=%0d got=%0b exp=1", i, in_ready); end
      if (i > 1) begin
        total++; if (out_valid !== 1'b1 || out_v !== W'(i - 1) || out_w !== (W'(i - 1) << 8))
          begin bad++; $display("FAIL stream_order i=%0d got v=%0d w=%h valid=%0b exp v=%0d", i, out_v, out_w, out_valid, i - 1); end
      end
      clk_step();
    end
    drive(1'b0, '0, '0, '0, '0, '0, 1'b1);
    total++; if (out_valid !== 1'b1 || out_v !== W'(8)) begin bad++; $display("FAIL stream_last got v=%0d valid=%0b exp v=8", out_v, out_valid); end
    clk_step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    set_t a, b, c;
    set_t seen[$];
    bit   c_taken;
    a = {64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5};
    b = {64'hB1, 64'hB2, 64'hB3, 64'hB4, 64'hB5};
    c = {64'hC1, 64'hC2, 64'hC3, 64'hC4, 64'hC5};
    drive(1'b1, a[5*W-1:4*W], a[4*W-1:3*W], a[3*W-1:2*W], a[2*W-1:W], a[W-1:0], 1'b0);
    clk_step();
    drive(1'b1, b[5*W-1:4*W], b[4*W-1:3*W], b[3*W-1:2*W], b[2*W-1:W], b[W-1:0], 1'b0);
    clk_step();
    drive(1'b1, c[5*W-1:4*W], c[4*W-1:3*W], c[3*W-1:2*W], c[2*W-1:W], c[W-1:0], 1'b0);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occupancy got=%0d exp=2", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
    clk_step();
    total++; if (occupancy !== 2'd2 || {out_v, out_w, out_x, out_y, out_z} !== a)
      begin bad++; $display("FAIL bp_hold got occ=%0d out_v=%h exp occ=2 out_v=a1", occupancy, out_v); end
    out_ready = 1'b1;
    c_taken = 1'b0;
    for (int cyc = 0; cyc < 10 && !(c_taken && mocc == 0); cyc++) begin
      if (out_valid === 1'b1) seen.push_back({out_v, out_w, out_x, out_y, out_z});
      clk_step();
      if (last_push) begin
        c_taken = 1'b1;
        in_valid = 1'b0;
      end
    end
    total++; if (seen.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", seen.size()); end
    else begin
      total++; if (seen[0] !== a || seen[1] !== b || seen[2] !== c)
        begin bad++; $display("FAIL bp_order got v=%h,%h,%h exp a1,b1,c1", seen[0][5*W-1:4*W], seen[1][5*W-1:4*W], seen[2][5*W-1:4*W]); end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_push_pop_one();
    drive(1'b1, 64'h1111, 64'h2222, 64'h3333, 64'h4444, 64'h5555, 1'b0);
    clk_step();
    drive(1'b1, 64'h6666, 64'h7777, 64'h8888, 64'h9999, 64'hAAAA, 1'b1);
    total++; if (out_v !== 64'h1111 || occupancy !== 2'd1) begin bad++; $display("FAIL pp_x got v=%h occ=%0d exp v=1111 occ=1", out_v, occupancy); end
    clk_step();
    in_valid = 1'b0;
    total++; if ({out_v, out_w, out_x, out_y, out_z} !== {64'h6666, 64'h7777, 64'h8888, 64'h9999, 64'hAAAA} || occupancy !== 2'd1)
      begin bad++; $display("FAIL pp_y got v=%h z=%h occ=%0d exp v=6666 z=aaaa occ=1", out_v, out_z, occupancy); end
    clk_step();
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 64'hDEAD, 64'hBEEF, 64'h1, 64'h2, 64'h3, 1'b0);
    clk_step();
    clk_step();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL mr_fill got=%0d exp=2", occupancy); end
    rst = 1'b1;
    drive(1'b1, 64'h5A5A, 64'h5A5A, 64'h5A5A, 64'h5A5A, 64'h5A5A, 1'b1);
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0)
      begin bad++; $display("FAIL mr_state got valid=%0b occ=%0d rdy=%0b exp 0/0/0", out_valid, occupancy, in_ready); end
    total++; if ({out_v, out_w, out_x, out_y, out_z} !== '0) begin bad++; $display("FAIL mr_data got=%h exp=0", {out_v, out_w, out_x, out_y, out_z}); end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mr_release got=%0b exp=1", in_ready); end
    mocc = 0; sb.delete(); raw_q.delete();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_no_capture got=%0b exp=0", out_valid); end
  endtask

  // Random valid/ready traffic; in the remask build rnd changes every cycle.
  task automatic test_random();
    int pushes = 0;
    int cyc = 0;
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
    while (pushes < 1000 && cyc < 6000) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_v = rnd64(); in_w = rnd64(); in_x = rnd64(); in_y = rnd64(); in_z = rnd64();
      end
      rnd = {rnd64(), rnd64(), rnd64(), rnd64()};
      out_ready = ($urandom_range(0, 3) != 0);
      total++; if (occupancy !== 2'(mocc) || out_valid !== (mocc != 0) || in_ready !== (mocc != 2))
        begin bad++; $display("FAIL rnd_ctrl cyc=%0d got occ=%0d valid=%0b rdy=%0b exp occ=%0d", cyc, occupancy, out_valid, in_ready, mocc); end
      if (mocc != 0) begin
        total++; if ({out_v, out_w, out_x, out_y, out_z} !== sb[0])
          begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, {out_v, out_w, out_x, out_y, out_z}, sb[0]); end
        total++; if ((out_v ^ out_w ^ out_x ^ out_y ^ out_z) !== raw_q[0])
          begin bad++; $display("FAIL rnd_unmasked cyc=%0d got=%h exp=%h", cyc, out_v ^ out_w ^ out_x ^ out_y ^ out_z, raw_q[0]); end
      end
      clk_step();
      if (last_push) begin
        pushes++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    total++; if (pushes < 1000) begin bad++; $display("FAIL rnd_budget got=%0d exp=1000 pushes", pushes); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4 && mocc != 0; k++) clk_step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_drain got=%0b exp=0", out_valid); end
  endtask

  initial begin
    rst = 1'b1;
    rnd = '0;
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    test_reset();
    test_single_push();
    test_stream();
    test_backpressure();
    test_push_pop_one();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
